// File: rtl/sdram_init_monitor_pkg.sv
// Shared SDRAM command encodings, timing defaults, error codes and monitor states.
// Also used by the SDRAM initializer so both sides agree on the power-up sequence.
package sdram_params;

    // Values match the sampled {cs_n, ras_n, cas_n, we_n} pattern
    typedef enum logic [3:0] {
        CMD_MODE_REG   = 4'b0000,
        CMD_REFRESH    = 4'b0001,
        CMD_PRECHARGE  = 4'b0010,
        CMD_ACTIVE     = 4'b0011,
        CMD_WRITE      = 4'b0100,
        CMD_READ       = 4'b0101,
        CMD_BURST_TERM = 4'b0110,
        CMD_NOP        = 4'b0111,
        CMD_DESELECT   = 4'b1111
    } cmd_t;

    typedef enum logic [2:0] {
        S_WAIT,
        S_PRE,
        S_REF,
        S_MRD,
        S_DONE,
        S_ERR
    } state_t;

    localparam int DEF_WAIT_INIT_CYCLE = 20000;
    localparam int DEF_MIN_REFRESH     = 8;
    localparam int T_RP                = 3;
    localparam int T_RC                = 9;
    localparam int T_MRD               = 2;

    localparam logic [3:0] ERR_NONE        = 4'd0;
    localparam logic [3:0] ERR_EARLY_CMD   = 4'd1;
    localparam logic [3:0] ERR_PRE_NOT_ALL = 4'd2;
    localparam logic [3:0] ERR_TRP         = 4'd3;
    localparam logic [3:0] ERR_TRC         = 4'd4;
    localparam logic [3:0] ERR_TMRD        = 4'd5;
    localparam logic [3:0] ERR_ILLEGAL_CMD = 4'd6;
    localparam logic [3:0] ERR_FEW_REFRESH = 4'd7;
    localparam logic [3:0] ERR_BAD_MODE    = 4'd8;

    // Only CAS latency 2 or 3, bank 0 and reserved bits [12:10] clear are accepted
    function automatic logic mode_is_bad(input logic [12:0] addr, input logic [1:0] ba);
        return (ba != 2'd0) || (addr[12:10] != 3'd0) ||
               !((addr[6:4] == 3'd2) || (addr[6:4] == 3'd3));
    endfunction

endpackage

// File: rtl/sdram_init_monitor_decode.sv
// Combinational decode of the SDRAM command pins into a command enum.
// DESELECT and NOP are both flagged as no-operation.
module sdram_cmd_decode
    import sdram_params::*;
(
    input  logic cs_n_i,
    input  logic ras_n_i,
    input  logic cas_n_i,
    input  logic we_n_i,
    output cmd_t cmd_o,
    output logic is_nop_o
);

    always_comb begin
        cmd_o = CMD_DESELECT;
        if (!cs_n_i) begin
            case ({ras_n_i, cas_n_i, we_n_i})
                3'b000:  cmd_o = CMD_MODE_REG;
                3'b001:  cmd_o = CMD_REFRESH;
                3'b010:  cmd_o = CMD_PRECHARGE;
                3'b011:  cmd_o = CMD_ACTIVE;
                3'b100:  cmd_o = CMD_WRITE;
                3'b101:  cmd_o = CMD_READ;
                3'b110:  cmd_o = CMD_BURST_TERM;
                default: cmd_o = CMD_NOP;
            endcase
        end
        is_nop_o = (cmd_o == CMD_NOP) || (cmd_o == CMD_DESELECT);
    end

endmodule

// File: rtl/sdram_init_monitor.sv
// Passive monitor of the SDRAM power-up sequence: NOP wait, precharge-all,
// auto-refreshes, mode-register set; reports completion or the first violation.
module sdram_init_monitor #(
    parameter int WAIT_INIT_CYCLE = sdram_params::DEF_WAIT_INIT_CYCLE,
    parameter int MIN_REFRESH     = sdram_params::DEF_MIN_REFRESH,
    parameter int T_RP            = sdram_params::T_RP,
    parameter int T_RC            = sdram_params::T_RC,
    parameter int T_MRD           = sdram_params::T_MRD
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        dram_cs_n,
    input  logic        dram_ras_n,
    input  logic        dram_cas_n,
    input  logic        dram_we_n,
    input  logic [12:0] dram_addr,
    input  logic [1:0]  dram_ba,
    output logic        init_done,
    output logic        error,
    output logic [3:0]  err_code,
    output logic [7:0]  refresh_count,
    output logic [12:0] mode_reg,
    output logic [2:0]  cas_latency,
    output logic [2:0]  burst_len
);
    import sdram_params::*;

    // A command at edge n permits the next one at edge n+T, i.e. wait_cnt >= T-1
    localparam logic [31:0] INIT_GAP = 32'(WAIT_INIT_CYCLE);
    localparam logic [31:0] RP_GAP   = 32'(T_RP - 1);
    localparam logic [31:0] RC_GAP   = 32'(T_RC - 1);
    localparam logic [31:0] MRD_GAP  = 32'(T_MRD - 1);

    cmd_t        cmd;
    logic        isNop;
    state_t      state_q;
    logic [31:0] wait_cnt_q;
    logic        init_done_q;
    logic        error_q;
    logic [3:0]  err_code_q;
    logic [7:0]  refresh_count_q;
    logic [12:0] mode_reg_q;
    logic [3:0]  viol;
    logic        initOk, rpOk, rcOk, mrdOk, enoughRef;

    sdram_cmd_decode u_decode (
        .cs_n_i   (dram_cs_n),
        .ras_n_i  (dram_ras_n),
        .cas_n_i  (dram_cas_n),
        .we_n_i   (dram_we_n),
        .cmd_o    (cmd),
        .is_nop_o (isNop)
    );

    assign initOk    = (wait_cnt_q >= INIT_GAP);
    assign rpOk      = (wait_cnt_q >= RP_GAP);
    assign rcOk      = (wait_cnt_q >= RC_GAP);
    assign mrdOk     = (wait_cnt_q >= MRD_GAP);
    assign enoughRef = (refresh_count_q >= 8'(MIN_REFRESH));

    // Classify the sampled command; at most one violation can occur per edge
    always_comb begin
        viol = ERR_NONE;
        if (!isNop) begin
            case (state_q)
                S_WAIT: begin
                    if (cmd != CMD_PRECHARGE)  viol = ERR_EARLY_CMD;
                    else if (!dram_addr[10])   viol = ERR_PRE_NOT_ALL;
                    else if (!initOk)          viol = ERR_EARLY_CMD;
                end
                S_PRE: begin
                    if (!rpOk)                      viol = ERR_TRP;
                    else if (cmd == CMD_MODE_REG)   viol = ERR_FEW_REFRESH;
                    else if (cmd != CMD_REFRESH)    viol = ERR_ILLEGAL_CMD;
                end
                S_REF: begin
                    case (cmd)
                        CMD_REFRESH, CMD_PRECHARGE: begin
                            if (!rcOk) viol = ERR_TRC;
                        end
                        CMD_MODE_REG: begin
                            if (!rcOk)                                  viol = ERR_TRC;
                            else if (!enoughRef)                        viol = ERR_FEW_REFRESH;
                            else if (mode_is_bad(dram_addr, dram_ba))   viol = ERR_BAD_MODE;
                        end
                        default: viol = ERR_ILLEGAL_CMD;
                    endcase
                end
                S_MRD: begin
                    if (!mrdOk) viol = ERR_TMRD;
                end
                default: viol = ERR_NONE;
            endcase
        end
    end

    // Sequence FSM; S_DONE and S_ERR are terminal so their outputs stay frozen
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q         <= S_WAIT;
            wait_cnt_q      <= '0;
            init_done_q     <= 1'b0;
            error_q         <= 1'b0;
            err_code_q      <= ERR_NONE;
            refresh_count_q <= '0;
            mode_reg_q      <= '0;
        end else begin
            if (!isNop)                 wait_cnt_q <= '0;
            else if (wait_cnt_q != '1)  wait_cnt_q <= wait_cnt_q + 32'd1;

            if (state_q == S_REF && cmd == CMD_MODE_REG && rcOk && enoughRef)
                mode_reg_q <= dram_addr;

            if (viol != ERR_NONE) begin
                state_q    <= S_ERR;
                error_q    <= 1'b1;
                err_code_q <= viol;
            end else begin
                case (state_q)
                    S_WAIT: if (!isNop) state_q <= S_PRE;
                    S_PRE: begin
                        if (cmd == CMD_REFRESH) begin
                            state_q         <= S_REF;
                            refresh_count_q <= 8'd1;
                        end
                    end
                    S_REF: begin
                        if (cmd == CMD_REFRESH && refresh_count_q != 8'hFF)
                            refresh_count_q <= refresh_count_q + 8'd1;
                        if (cmd == CMD_MODE_REG)
                            state_q <= S_MRD;
                    end
                    S_MRD: begin
                        if (mrdOk) begin
                            init_done_q <= 1'b1;
                            state_q     <= S_DONE;
                        end
                    end
                    default: state_q <= state_q;
                endcase
            end
        end
    end

    assign init_done     = init_done_q;
    assign error         = error_q;
    assign err_code      = err_code_q;
    assign refresh_count = refresh_count_q;
    assign mode_reg      = mode_reg_q;
    assign cas_latency   = mode_reg_q[6:4];
    assign burst_len     = mode_reg_q[2:0];

endmodule

// File: doc/sdram_init_monitor.md
Name: sdram_init_monitor

Overview:
Passive checker on the SDRAM command/address pins, sitting at the device end of the bus. It decodes every sampled command and verifies the power-up sequence in order: NOP wait, precharge-all, N auto-refreshes, then mode-register set. It enforces tRP, tRC and tMRD spacing, captures the programmed mode register, and raises done or a sticky error code. It is used on-chip beside the SDRAM pins and in benches.

Parameters:
WAIT_INIT_CYCLE, 20000, minimum clocks of NOP/deselect after reset before the first non-NOP command
MIN_REFRESH, 8, minimum REFRESH commands required before MODE_REG
T_RP, 3, minimum clocks from PRECHARGE to the next non-NOP command
T_RC, 9, minimum clocks from REFRESH to the next non-NOP command
T_MRD, 2, minimum clocks from MODE_REG to init_done

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high
dram_cs_n  in  1  chip select
dram_ras_n  in  1  RAS
dram_cas_n  in  1  CAS
dram_we_n  in  1  WE
dram_addr  in  13  address; A10 is the precharge-all flag
dram_ba  in  2  bank address
init_done  out  1  sequence completed legally; sticky
error  out  1  violation detected; sticky
err_code  out  4  first violation code; 0 means none
refresh_count  out  8  REFRESH commands accepted, saturates at 255
mode_reg  out  13  dram_addr captured at MODE_REG
cas_latency  out  3  mode_reg[6:4]
burst_len  out  3  mode_reg[2:0]

Behaviour:
- Command decode {cs_n,ras_n,cas_n,we_n}: 1xxx DESELECT (treated as NOP); 0111 NOP; 0010 PRECHARGE; 0001 REFRESH; 0000 MODE_REG; 0011 ACTIVE; 0101 READ; 0100 WRITE; 0110 BURST_TERM.
- Pins are sampled at posedge clk. "Non-NOP" means any command other than NOP or DESELECT.
- Reset: all outputs 0. State goes to S_WAIT and wait_cnt goes to 0. Reset mid-sequence restarts from S_WAIT with no residue.
- wait_cnt is 32 bits. It clears on each accepted non-NOP command, otherwise increments and saturates at all-ones. Spacing rule: a command sampled at edge n allows the next non-NOP at edge n+T or later, which means wait_cnt >= T-1 when it is sampled.
- States:
  - S_WAIT: NOP increments the count. PRECHARGE with wait_cnt >= WAIT_INIT_CYCLE and A10=1 -> S_PRE. PRECHARGE with A10=0 -> ERR code 2. Any other non-NOP, or PRECHARGE too early -> ERR code 1.
  - S_PRE: REFRESH legally spaced -> S_REF, refresh_count=1. Non-NOP inside tRP -> ERR code 3. Legally spaced MODE_REG -> ERR 7. Other non-NOP -> ERR 6.
  - S_REF: REFRESH inside tRC -> ERR 4. REFRESH legally spaced -> refresh_count++. MODE_REG inside tRC -> ERR 4. MODE_REG legally spaced with refresh_count < MIN_REFRESH -> ERR 7. MODE_REG legally spaced with refresh_count >= MIN_REFRESH: capture mode_reg, then check BA!=0, addr[12:10]!=0, or CAS latency not 2/3 -> ERR 8, else -> S_MRD. PRECHARGE legally spaced -> stay in S_REF (count kept). Other non-NOP -> ERR 6.
  - S_MRD: any non-NOP while wait_cnt < T_MRD-1 -> ERR 5. On the edge where wait_cnt reaches T_MRD-1, init_done <= 1 and -> S_DONE (registered, visible the following cycle).
  - S_DONE: terminal; all commands ignored; outputs frozen.
  - S_ERR: terminal until reset. error=1. err_code holds the first code and is never overwritten.
- Only one command exists per cycle, so at most one violation per edge; there is no priority logic.
- Error codes: 1 EARLY_CMD, 2 PRE_NOT_ALL, 3 TRP, 4 TRC, 5 TMRD, 6 ILLEGAL_CMD, 7 FEW_REFRESH, 8 BAD_MODE.
- init_done and error are mutually exclusive.

Decomposition:
- Shared parameter package sdram_params: command encodings (CMD_NOP, CMD_PRECHARGE, CMD_REFRESH, CMD_MODE_REG, CMD_ACTIVE, CMD_READ, CMD_WRITE, CMD_BURST_TERM), timing constants T_RP/T_RC/T_MRD, error-code constants, state encodings. The same package is used by the initializer.
- Sub-module sdram_cmd_decode: combinational pins-to-command enum plus is_nop flag. Everything else stays in one FSM.

Test Plan:
- Legal sequence with WAIT_INIT_CYCLE=16: 17 NOPs, PRECHARGE A10=1, 2 NOPs, 8 REFRESH each followed by 8 NOPs, MODE_REG addr=0x021, 2 NOPs -> init_done=1, error=0, refresh_count=8, cas_latency=2, burst_len=1.
- REFRESH issued at wait_cnt=10 with no prior precharge -> err_code=1; later commands leave the code unchanged.
- PRECHARGE with A10=0 after the wait -> err_code=2. Repeat with a legal precharge, then REFRESH one clock later (T_RP=3) -> err_code=3.
- Second REFRESH 5 clocks after the first (T_RC=9) -> err_code=4, refresh_count=1.
- MODE_REG after 7 refreshes -> err_code=7. MODE_REG addr=0x051 (CL=5) after 8 refreshes -> err_code=8, mode_reg=0x051.
- Assert reset while in S_REF, then replay the full legal sequence -> all outputs 0 during reset, then init_done=1 with refresh_count=8 (no carry-over).
